// File: rtl/bilbo_bist_ctrl_pkg.sv
// Shared types for the BILBO self-test controller:
// chain mode encodings and FSM state encoding.
package bilbo_bist_ctrl_pkg;

   // {b1,b2} mode pins of the BILBO chain
   localparam logic [1:0] MODE_NORMAL = 2'b11;
   localparam logic [1:0] MODE_SHIFT  = 2'b01;
   localparam logic [1:0] MODE_MISR   = 2'b10;
   localparam logic [1:0] MODE_CLEAR  = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_SEED   = 3'd2,
      S_RUN    = 3'd3,
      S_UNLOAD = 3'd4,
      S_CHECK  = 3'd5
   } state_t;

endpackage

// File: rtl/bist_down_cnt.sv
// Loadable down-counter with zero flag; holds at zero.
// Ports: clk, rst_n, clr (sync clear), load/load_val, dec, zero.
module bist_down_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   assign zero = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/bilbo_bist_ctrl.sv
// BILBO self-test sequencer: clear, seed, MISR run, unload, compare.
// Ports: clk, rst_n, start, abort, seed, run_len, golden, scan_in ->
//        b1, b2, tdi, busy, done, pass, signature (all registered).
module bilbo_bist_ctrl
   import bilbo_bist_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] seed,
   input  logic [CNT_W-1:0] run_len,
   input  logic [WIDTH-1:0] golden,
   input  logic             scan_in,
   output logic             b1,
   output logic             b2,
   output logic             tdi,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH-1:0] signature
);

   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [1:0]       mode;
   logic [WIDTH-1:0] seed_q;
   logic [CNT_W-1:0] rl_q;
   logic [WIDTH-1:0] gold_q;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_dec;
   logic             cnt_zero;

   assign b1 = mode[1];
   assign b2 = mode[0];

   // Counter is reloaded on the edge that enters a counted state
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      unique case (state)
         S_CLEAR: begin
            cnt_load = 1'b1;
            cnt_val  = W_LAST;
         end
         S_SEED: begin
            if (cnt_zero) begin
               cnt_load = 1'b1;
               cnt_val  = (rl_q != '0) ?
                          rl_q - CNT_W'(1) : W_LAST;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_RUN: begin
            if (cnt_zero) begin
               cnt_load = 1'b1;
               cnt_val  = W_LAST;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_UNLOAD: cnt_dec = 1'b1;
         default: ;
      endcase
   end

   bist_down_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (abort),
      .load    (cnt_load),
      .load_val(cnt_val),
      .dec     (cnt_dec),
      .zero    (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         mode      <= MODE_NORMAL;
         tdi       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         signature <= '0;
         seed_q    <= '0;
         rl_q      <= '0;
         gold_q    <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
            mode  <= MODE_NORMAL;
            tdi   <= 1'b0;
            busy  <= 1'b0;
            pass  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     state     <= S_CLEAR;
                     mode      <= MODE_CLEAR;
                     busy      <= 1'b1;
                     pass      <= 1'b0;
                     signature <= '0;
                     seed_q    <= seed;
                     rl_q      <= run_len;
                     gold_q    <= golden;
                  end
               end
               S_CLEAR: begin
                  // seed shifts out lsb first
                  state  <= S_SEED;
                  mode   <= MODE_SHIFT;
                  tdi    <= seed_q[0];
                  seed_q <= {1'b0, seed_q[WIDTH-1:1]};
               end
               S_SEED: begin
                  if (cnt_zero) begin
                     tdi <= 1'b0;
                     if (rl_q != '0) begin
                        state <= S_RUN;
                        mode  <= MODE_MISR;
                     end else begin
                        state <= S_UNLOAD;
                        mode  <= MODE_SHIFT;
                     end
                  end else begin
                     tdi    <= seed_q[0];
                     seed_q <= {1'b0, seed_q[WIDTH-1:1]};
                  end
               end
               S_RUN: begin
                  if (cnt_zero) begin
                     state <= S_UNLOAD;
                     mode  <= MODE_SHIFT;
                  end
               end
               S_UNLOAD: begin
                  signature <= {scan_in, signature[WIDTH-1:1]};
                  if (cnt_zero) begin
                     state <= S_CHECK;
                     mode  <= MODE_NORMAL;
                  end
               end
               S_CHECK: begin
                  state <= S_IDLE;
                  pass  <= (signature == gold_q);
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  mode  <= MODE_NORMAL;
                  tdi   <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bilbo_bist_ctrl.sv
// Bench for bilbo_bist_ctrl with a 4-cell BILBO chain model.
// Scoreboard of expected sessions, checked by a done monitor.
module tb_bilbo_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [3:0] seed;
   logic [7:0] run_len;
   logic [3:0] golden;
   logic       scan_in;
   logic       b1;
   logic       b2;
   logic       tdi;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] signature;

   int total = 0;
   int npass = 0;
   int cyc = 0;

   typedef struct {
      logic [3:0] sig;
      logic       pass;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   logic [3:0] chain;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // chain: first cell is chain[3], last is chain[0]; z inputs tied 0
   always @(posedge clk) begin
      case ({b1, b2})
         2'b11: chain <= 4'h0;
         2'b10: chain <= {chain[0] ^ chain[1], chain[3:1]};
         2'b01: chain <= {tdi, chain[3:1]};
         default: chain <= 4'h0;
      endcase
   end

   assign scan_in = chain[0];

   bilbo_bist_ctrl #(
      .WIDTH(4),
      .CNT_W(8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .seed     (seed),
      .run_len  (run_len),
      .golden   (golden),
      .scan_in  (scan_in),
      .b1       (b1),
      .b2       (b2),
      .tdi      (tdi),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .signature(signature)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) npass++;
      else $display("FAIL %s actual=%0h required=%0h",
                    nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("signature", 32'(signature), 32'(e.sig));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic go(input logic [3:0] s,
                     input logic [7:0] r,
                     input logic [3:0] g,
                     input bit         push,
                     input logic [3:0] esig,
                     input logic       epass,
                     input int         lat);
      seed    = s;
      run_len = r;
      golden  = g;
      start   = 1'b1;
      if (push) sb.push_back('{esig, epass, cyc + lat});
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      chk("drain_left", sb.size(), 0);
      sb.delete();
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_b1"}, 32'(b1), 32'd1);
      chk({tag, "_b2"}, 32'(b2), 32'd1);
      chk({tag, "_tdi"}, 32'(tdi), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_sig"}, 32'(signature), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      seed    = 4'h0;
      run_len = 8'd0;
      golden  = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // no run: signature is the seed itself
      go(4'hA, 8'd0, 4'hA, 1, 4'hA, 1'b1, 11);
      drain();

      // 8 MISR cycles from seed 1 give 4'h5
      go(4'h1, 8'd8, 4'h5, 1, 4'h5, 1'b1, 19);
      drain();
      go(4'h1, 8'd8, 4'h4, 1, 4'h5, 1'b0, 19);
      drain();

      // abort sampled on the 3rd RUN cycle
      go(4'h1, 8'd8, 4'h5, 0, 4'h0, 1'b0, 0);
      repeat (7) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_b1", 32'(b1), 32'd1);
      chk("abort_b2", 32'(b2), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_tdi", 32'(tdi), 32'd0);
      repeat (25) @(posedge clk);
      #1;
      go(4'h1, 8'd8, 4'h5, 1, 4'h5, 1'b1, 19);
      drain();

      // start while busy must be ignored
      go(4'h1, 8'd8, 4'h5, 1, 4'h5, 1'b1, 19);
      repeat (2) @(posedge clk);
      #1;
      go(4'hF, 8'd0, 4'h0, 0, 4'h0, 1'b0, 0);
      repeat (6) @(posedge clk);
      #1;
      go(4'h0, 8'd3, 4'hF, 0, 4'h0, 1'b0, 0);
      drain();
      repeat (10) @(posedge clk);
      #1;

      // async reset during UNLOAD
      go(4'hA, 8'd0, 4'hA, 1, 4'hA, 1'b1, 11);
      repeat (6) @(posedge clk);
      #1;
      chk("busy_mid", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      go(4'h3, 8'd0, 4'h3, 1, 4'h3, 1'b1, 11);
      drain();

      $display("%0d/%0d checks passed", npass, total);
      $finish;
   end

endmodule
